nubus_mem_arbiter: RTL and testbench

NUBUS_MEM_ARBITER -- requirements
Module: nubus_mem_arbiter

---
 rtl/nubus_pkg.sv | 17 +
 rtl/nubus_wait_timer.sv | 35 +++
 rtl/nubus_mem_arbiter.sv | 128 ++++++++++++
 tb/tb_nubus_mem_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nubus_pkg.sv
// Shared NuBus definitions: arbiter state encoding, port indices and the tie-break helper.
package nubus_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic PORT0 = 1'b0;  // NuBus slave
  localparam logic PORT1 = 1'b1;  // local CPU

  // Winner when both ports request together; round-robin favours the port not served last.
  function automatic logic tie_winner(input logic port1_priority, input logic last_served);
    return port1_priority ? PORT1 : ~last_served;
  endfunction

endpackage

// File: rtl/nubus_wait_timer.sv
// 16-bit wait counter: cleared by clear, advanced by enable, flags expiry when count hits limit.
module nubus_wait_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] limit,
  output logic        expired
);

  logic [15:0] count_q;
  logic [15:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 16'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Expiry only counts on a cycle that would otherwise keep waiting.
  assign expired = enable && (count_q == limit);

endmodule

// File: rtl/nubus_mem_arbiter.sv
// Two-port arbiter in front of the shared card memory: NuBus slave (port 0) and local CPU (port 1).
module nubus_mem_arbiter
  import nubus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter bit PORT1_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s0_valid,
  input  logic [3:0]  s0_write,
  input  logic [31:0] s0_addr,
  input  logic [31:0] s0_wdata,
  output logic        s0_ready,
  output logic        s0_timeout,
  input  logic        s1_valid,
  input  logic [3:0]  s1_write,
  input  logic [31:0] s1_addr,
  input  logic [31:0] s1_wdata,
  output logic        s1_ready,
  output logic        s1_timeout,
  output logic [31:0] s_rdata,
  output logic        m_valid,
  output logic [3:0]  m_write,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_ready,
  input  logic [31:0] m_rdata
);

  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;
  logic [3:0]  m_write_q, m_write_d;
  logic [31:0] m_addr_q, m_addr_d;
  logic [31:0] m_wdata_q, m_wdata_d;

  logic in_grant;
  logic grant_port;
  logic next_port;
  logic wait_expired;

  assign in_grant   = (state_q == GRANT0) || (state_q == GRANT1);
  assign grant_port = (state_q == GRANT1) ? PORT1 : PORT0;

  nubus_wait_timer u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!in_grant),
    .enable  (in_grant && !m_ready),
    .limit   (WAIT_LIMIT),
    .expired (wait_expired)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    last_d     = last_q;
    m_write_d  = m_write_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    next_port  = PORT0;
    s0_ready   = 1'b0;
    s1_ready   = 1'b0;
    s0_timeout = 1'b0;
    s1_timeout = 1'b0;
    s_rdata    = '0;

    case (state_q)
      IDLE: begin
        if (s0_valid || s1_valid) begin
          if (s0_valid && s1_valid) begin
            next_port = tie_winner(PORT1_PRIORITY, last_q);
          end else begin
            next_port = s1_valid ? PORT1 : PORT0;
          end
          state_d   = (next_port == PORT1) ? GRANT1 : GRANT0;
          m_write_d = (next_port == PORT1) ? s1_write : s0_write;
          m_addr_d  = (next_port == PORT1) ? s1_addr  : s0_addr;
          m_wdata_d = (next_port == PORT1) ? s1_wdata : s0_wdata;
        end
      end

      GRANT0, GRANT1: begin
        // Completion is checked first so it wins over a coinciding timeout.
        if (m_ready) begin
          s0_ready = (grant_port == PORT0);
          s1_ready = (grant_port == PORT1);
          s_rdata  = m_rdata;
          last_d   = grant_port;
          state_d  = DONE;
        end else if (wait_expired) begin
          s0_timeout = (grant_port == PORT0);
          s1_timeout = (grant_port == PORT1);
          last_d     = grant_port;
          state_d    = DONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= PORT1;
      m_write_q <= '0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      m_write_q <= m_write_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign m_valid = in_grant;
  assign m_write = m_write_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

endmodule

// File: tb/tb_nubus_mem_arbiter.sv
// Bench for nubus_mem_arbiter: a round-robin and a port-1-priority instance share all inputs.
module tb_nubus_mem_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        s0_valid, s1_valid, m_ready;
  logic [3:0]  s0_write, s1_write;
  logic [31:0] s0_addr, s1_addr, s0_wdata, s1_wdata, m_rdata;

  logic        rr_s0_ready, rr_s1_ready, rr_s0_timeout, rr_s1_timeout, rr_m_valid;
  logic [3:0]  rr_m_write;
  logic [31:0] rr_s_rdata, rr_m_addr, rr_m_wdata;
  logic        p1_s0_ready, p1_s1_ready, p1_s0_timeout, p1_s1_timeout, p1_m_valid;
  logic [3:0]  p1_m_write;
  logic [31:0] p1_s_rdata, p1_m_addr, p1_m_wdata;

  always #5 clk = ~clk;

  nubus_mem_arbiter #(.TIMEOUT_CYCLES(TO), .PORT1_PRIORITY(1'b0)) u_rr (
    .clk(clk), .reset(reset),
    .s0_valid(s0_valid), .s0_write(s0_write), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
    .s0_ready(rr_s0_ready), .s0_timeout(rr_s0_timeout),
    .s1_valid(s1_valid), .s1_write(s1_write), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
    .s1_ready(rr_s1_ready), .s1_timeout(rr_s1_timeout),
    .s_rdata(rr_s_rdata), .m_valid(rr_m_valid), .m_write(rr_m_write), .m_addr(rr_m_addr),
    .m_wdata(rr_m_wdata), .m_ready(m_ready), .m_rdata(m_rdata)
  );

  nubus_mem_arbiter #(.TIMEOUT_CYCLES(TO), .PORT1_PRIORITY(1'b1)) u_p1 (
    .clk(clk), .reset(reset),
    .s0_valid(s0_valid), .s0_write(s0_write), .s0_addr(s0_addr), .s0_wdata(s0_wdata),
    .s0_ready(p1_s0_ready), .s0_timeout(p1_s0_timeout),
    .s1_valid(s1_valid), .s1_write(s1_write), .s1_addr(s1_addr), .s1_wdata(s1_wdata),
    .s1_ready(p1_s1_ready), .s1_timeout(p1_s1_timeout),
    .s_rdata(p1_s_rdata), .m_valid(p1_m_valid), .m_write(p1_m_write), .m_addr(p1_m_addr),
    .m_wdata(p1_m_wdata), .m_ready(m_ready), .m_rdata(m_rdata)
  );

  typedef struct {
    logic        port;
    logic [3:0]  write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ready_at;  // grant cycle (1 = first m_valid cycle) with m_ready high; 0 = never
  } vec_t;

  typedef struct {
    logic        port;
    logic        timeout;
    logic [31:0] rdata;
    int          cycle;
  } exp_t;

  exp_t sb_q[$];
  logic rr_order_q[$];
  logic p1_order_q[$];
  vec_t vecs[6];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rr_zero(input string tag);
    check({tag, " m_valid"}, rr_m_valid, 0);
    check({tag, " m_write"}, rr_m_write, 0);
    check({tag, " m_addr"},  rr_m_addr, 0);
    check({tag, " m_wdata"}, rr_m_wdata, 0);
    check({tag, " s_rdata"}, rr_s_rdata, 0);
    check({tag, " strobes"}, {rr_s0_ready, rr_s1_ready, rr_s0_timeout, rr_s1_timeout}, 0);
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b0;
    s0_write = '0;   s1_write = '0;
    s0_addr  = '0;   s1_addr  = '0;
    s0_wdata = '0;   s1_wdata = '0;
    m_rdata  = '0;
    repeat (2) @(posedge clk);
    #1;
    check_rr_zero("reset");
    check("reset p1 m_valid", p1_m_valid, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    exp_t got;
    logic seen;
    string tag;
    tag = $sformatf("vec%0d", idx);
    tick();
    s0_valid = (v.port == 1'b0);
    s1_valid = (v.port == 1'b1);
    s0_write = v.port ? ~v.write : v.write;
    s1_write = v.port ? v.write : ~v.write;
    s0_addr  = v.port ? ~v.addr : v.addr;
    s1_addr  = v.port ? v.addr : ~v.addr;
    s0_wdata = v.port ? ~v.wdata : v.wdata;
    s1_wdata = v.port ? v.wdata : ~v.wdata;
    e.port    = v.port;
    e.timeout = (v.ready_at == 0);
    e.rdata   = e.timeout ? 32'h0 : v.rdata;
    e.cycle   = e.timeout ? TO : v.ready_at;
    sb_q.push_back(e);
    #1;
    check({tag, " m_valid before grant"}, rr_m_valid, 0);
    seen = 1'b0;
    for (int cyc = 1; cyc <= TO + 4 && !seen; cyc++) begin
      tick();
      if (cyc == 1) begin
        // Requester drops valid and scrambles its fields; the grant must hold.
        s0_valid = 1'b0; s1_valid = 1'b0;
        s0_addr  = 32'h1111_1111; s1_addr  = 32'h2222_2222;
        s0_wdata = 32'h3333_3333; s1_wdata = 32'h4444_4444;
        s0_write = 4'h5;          s1_write = 4'hA;
      end
      m_ready = (cyc == v.ready_at);
      m_rdata = m_ready ? v.rdata : 32'hA5A5_5A5A;
      #1;
      if (cyc == 1) begin
        check({tag, " m_valid latency"}, rr_m_valid, 1);
        check({tag, " m_addr"},  rr_m_addr, v.addr);
        check({tag, " m_write"}, rr_m_write, {28'h0, v.write});
      end
      if (rr_s0_ready || rr_s1_ready || rr_s0_timeout || rr_s1_timeout) begin
        seen        = 1'b1;
        got.port    = rr_s1_ready | rr_s1_timeout;
        got.timeout = rr_s0_timeout | rr_s1_timeout;
        got.rdata   = rr_s_rdata;
        got.cycle   = cyc;
        check({tag, " m_wdata held"}, rr_m_wdata, v.wdata);
        check({tag, " m_valid during strobe"}, rr_m_valid, 1);
        check({tag, " other port silent"},
              v.port ? {rr_s0_ready, rr_s0_timeout} : {rr_s1_ready, rr_s1_timeout}, 0);
        check({tag, " ready xor timeout"},
              (rr_s0_ready | rr_s1_ready) & (rr_s0_timeout | rr_s1_timeout), 0);
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL %s unexpected strobe: scoreboard empty", tag);
        end else begin
          e = sb_q.pop_front();
          check({tag, " port"},    got.port, e.port);
          check({tag, " timeout"}, got.timeout, e.timeout);
          check({tag, " s_rdata"}, got.rdata, e.rdata);
          check({tag, " cycle"},   got.cycle, e.cycle);
        end
      end else begin
        check({tag, " s_rdata idle"}, rr_s_rdata, 0);
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s no strobe within %0d cycles", tag, TO + 4);
      sb_q.delete();
    end
    tick();
    m_ready = 1'b1;
    m_rdata = 32'hFEED_F00D;
    #1;
    check({tag, " DONE m_valid"}, rr_m_valid, 0);
    check({tag, " DONE strobes"}, {rr_s0_ready, rr_s1_ready, rr_s0_timeout, rr_s1_timeout}, 0);
    check({tag, " DONE s_rdata"}, rr_s_rdata, 0);
    m_ready = 1'b0;
    tick();
    check({tag, " IDLE m_valid"}, rr_m_valid, 0);
  endtask

  task automatic run_tie();
    logic p;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      rr_order_q.push_back(i[0]);
      p1_order_q.push_back(1'b1);
    end
    tick();
    s0_valid = 1'b1; s0_write = 4'h0; s0_addr = 32'h0000_0100; s0_wdata = 32'h0;
    s1_valid = 1'b1; s1_write = 4'h0; s1_addr = 32'h0000_0200; s1_wdata = 32'h0;
    m_ready  = 1'b1; m_rdata  = 32'h0BAD_CAFE;
    for (int cyc = 0; cyc < 30 && (rr_order_q.size() > 0 || p1_order_q.size() > 0); cyc++) begin
      tick();
      if (rr_s0_ready || rr_s1_ready) begin
        if (rr_order_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tie rr extra grant at cycle %0d", cyc);
        end else begin
          p = rr_order_q.pop_front();
          check($sformatf("tie rr grant %0d", 4 - rr_order_q.size()), rr_s1_ready, p);
          check("tie rr m_addr", rr_m_addr, p ? 32'h0000_0200 : 32'h0000_0100);
          check("tie rr s_rdata", rr_s_rdata, 32'h0BAD_CAFE);
        end
      end
      if (p1_s0_ready || p1_s1_ready) begin
        if (p1_order_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tie p1 extra grant at cycle %0d", cyc);
        end else begin
          p = p1_order_q.pop_front();
          check($sformatf("tie p1 grant %0d", 4 - p1_order_q.size()), p1_s1_ready, p);
          check("tie p1 m_addr", p1_m_addr, 32'h0000_0200);
        end
      end
    end
    if (rr_order_q.size() != 0 || p1_order_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL tie grants missing: rr %0d, p1 %0d left", rr_order_q.size(), p1_order_q.size());
      rr_order_q.delete();
      p1_order_q.delete();
    end
    s0_valid = 1'b0; s1_valid = 1'b0; m_ready = 1'b0;
  endtask

  task automatic run_reset_mid_grant();
    apply_reset();
    tick();
    s1_valid = 1'b1; s1_write = 4'b0011; s1_addr = 32'h0000_0040; s1_wdata = 32'h0000_ABCD;
    m_ready  = 1'b0; m_rdata  = 32'h1234_5678;
    tick();
    tick();
    check("rst grant m_valid", rr_m_valid, 1);
    #1 reset = 1'b1;
    #1 check_rr_zero("mid-grant reset");
    @(negedge clk);
    reset = 1'b0;
    #1 check("post-release m_valid", rr_m_valid, 0);
    tick();
    check("regrant m_valid", rr_m_valid, 1);
    check("regrant m_write", rr_m_write, 32'h3);
    check("regrant m_addr",  rr_m_addr, 32'h0000_0040);
    check("regrant m_wdata", rr_m_wdata, 32'h0000_ABCD);
    s1_valid = 1'b0;
    m_ready  = 1'b1;
    #1;
    check("regrant s1_ready",   rr_s1_ready, 1);
    check("regrant s1_timeout", rr_s1_timeout, 0);
    check("regrant s_rdata",    rr_s_rdata, 32'h1234_5678);
    tick();
    m_ready = 1'b0;
  endtask

  initial begin
    vecs[0] = '{port: 1'b0, write: 4'h0, addr: 32'hF500_0010, wdata: 32'h0,
                rdata: 32'hDEAD_BEEF, ready_at: 3};
    vecs[1] = '{port: 1'b1, write: 4'b0011, addr: 32'h0000_1000, wdata: 32'h0000_ABCD,
                rdata: 32'h0, ready_at: 1};
    vecs[2] = '{port: 1'b0, write: 4'hF, addr: 32'hF500_0020, wdata: 32'hCAFE_0001,
                rdata: 32'h0, ready_at: 0};
    vecs[3] = '{port: 1'b1, write: 4'h0, addr: 32'h0000_2004, wdata: 32'h0,
                rdata: 32'h5555_AAAA, ready_at: TO};
    vecs[4] = '{port: 1'b1, write: 4'b1000, addr: 32'h0000_3008, wdata: 32'h8000_0000,
                rdata: 32'h0, ready_at: 0};
    vecs[5] = '{port: 1'b0, write: 4'h0, addr: 32'hF5FF_FFFC, wdata: 32'h0,
                rdata: 32'h0123_4567, ready_at: TO - 1};

    apply_reset();
    for (int i = 0; i < 6; i++) begin
      run_vec(i, vecs[i]);
    end
    run_tie();
    run_reset_mid_grant();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
